// File: rtl/mu_pos_updater_pkg.sv
// Shared widths, FSM state encoding and the output FIFO entry layout for the
// per-cell motion-update engine.
package mu_pos_updater_pkg;

    localparam int unsigned OFFSET_WIDTH         = 8;
    localparam int unsigned OFFSET_STRUCT_WIDTH  = 3 * OFFSET_WIDTH;
    localparam int unsigned ELEMENT_WIDTH        = 4;
    localparam int unsigned PARTICLE_ID_WIDTH    = 8;
    localparam int unsigned GLOBAL_CELL_ID_WIDTH = 3;
    localparam int unsigned DELTA_WIDTH          = OFFSET_WIDTH + 1;

    localparam int unsigned NUM_CELLS_X = 3;
    localparam int unsigned NUM_CELLS_Y = 3;
    localparam int unsigned NUM_CELLS_Z = 3;

    localparam int unsigned MU_FIFO_DEPTH = 2;
    localparam int unsigned MU_FIFO_PTR_W = $clog2(MU_FIFO_DEPTH);
    localparam int unsigned MU_FIFO_CNT_W = $clog2(MU_FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_NUM,
        ST_WAIT_NUM,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } mu_state_e;

    typedef struct packed {
        logic [OFFSET_STRUCT_WIDTH-1:0]    pos;
        logic [ELEMENT_WIDTH-1:0]          element;
        logic [3*GLOBAL_CELL_ID_WIDTH-1:0] gcid;
    } mu_fifo_entry_t;

endpackage

// File: rtl/mu_cell_wrap.sv
// One axis of the position update: offset + signed delta, with at most one
// cell crossing and periodic wrap of the cell index.
module mu_cell_wrap #(
    parameter int unsigned OFFSET_WIDTH = 8,
    parameter int unsigned DELTA_WIDTH  = 9,
    parameter int unsigned CELL_WIDTH   = 3,
    parameter int unsigned NUM_CELLS    = 3
) (
    input  logic [OFFSET_WIDTH-1:0] i_offset,
    input  logic [DELTA_WIDTH-1:0]  i_delta,
    input  logic [CELL_WIDTH-1:0]   i_cell,
    output logic [OFFSET_WIDTH-1:0] o_offset,
    output logic [CELL_WIDTH-1:0]   o_cell
);

    localparam int unsigned SW = DELTA_WIDTH + 2;

    logic signed [SW-1:0] sum;
    logic                 over;
    logic                 under;

    always_comb begin
        sum   = $signed({{(SW-OFFSET_WIDTH){1'b0}}, i_offset})
              + $signed({{(SW-DELTA_WIDTH){i_delta[DELTA_WIDTH-1]}}, i_delta});
        under = sum[SW-1];
        over  = !sum[SW-1] && (sum[SW-2:OFFSET_WIDTH] != '0);
        // Adding or removing 2^OFFSET_WIDTH leaves the low bits untouched.
        o_offset = sum[OFFSET_WIDTH-1:0];
        o_cell   = i_cell;
        if (over) begin
            o_cell = (i_cell == CELL_WIDTH'(NUM_CELLS - 1)) ? '0 : i_cell + 1'b1;
        end else if (under) begin
            o_cell = (i_cell == '0) ? CELL_WIDTH'(NUM_CELLS - 1) : i_cell - 1'b1;
        end
    end

endmodule

// File: rtl/mu_skid_fifo.sv
// Two-entry output FIFO holding updated particles until the write bus grants.
module mu_skid_fifo
    import mu_pos_updater_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  mu_fifo_entry_t           i_push_data,
    input  logic                     i_pop,
    output mu_fifo_entry_t           o_head,
    output logic                     o_empty,
    output logic [MU_FIFO_CNT_W-1:0] o_count
);

    mu_fifo_entry_t             mem_q [MU_FIFO_DEPTH];
    mu_fifo_entry_t             mem_d [MU_FIFO_DEPTH];
    logic [MU_FIFO_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [MU_FIFO_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [MU_FIFO_CNT_W-1:0]   count_q, count_d;
    logic                       pop_ok;
    logic                       push_ok;

    always_comb begin
        pop_ok   = i_pop && (count_q != '0);
        push_ok  = i_push && ((count_q != MU_FIFO_CNT_W'(MU_FIFO_DEPTH)) || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = i_push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + MU_FIFO_CNT_W'(push_ok) - MU_FIFO_CNT_W'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MU_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            assert (!(i_push && !push_ok))
                else $error("mu_skid_fifo: push into full FIFO");
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_empty = (count_q == '0);
    assign o_count = count_q;

endmodule

// File: rtl/mu_pos_updater.sv
// Per-cell motion-update engine: streams particles out of the position cache,
// applies displacements, resolves destination cell and broadcasts on the MU bus.
module mu_pos_updater
    import mu_pos_updater_pkg::*;
#(
    parameter logic [GLOBAL_CELL_ID_WIDTH-1:0] GCELL_X = 3'h0,
    parameter logic [GLOBAL_CELL_ID_WIDTH-1:0] GCELL_Y = 3'h0,
    parameter logic [GLOBAL_CELL_ID_WIDTH-1:0] GCELL_Z = 3'h0,
    parameter int unsigned NUM_CELLS_X = mu_pos_updater_pkg::NUM_CELLS_X,
    parameter int unsigned NUM_CELLS_Y = mu_pos_updater_pkg::NUM_CELLS_Y,
    parameter int unsigned NUM_CELLS_Z = mu_pos_updater_pkg::NUM_CELLS_Z,
    parameter int unsigned DELTA_WIDTH = mu_pos_updater_pkg::DELTA_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    i_MU_start,
    output logic                                    o_MU_working,
    output logic [PARTICLE_ID_WIDTH-1:0]            o_MU_rd_addr,
    output logic                                    o_MU_rd_en,
    input  logic                                    i_MU_offset_valid,
    input  logic [OFFSET_STRUCT_WIDTH+ELEMENT_WIDTH-1:0] i_pos_pkt,
    input  logic [3*DELTA_WIDTH-1:0]                i_delta,
    output logic                                    o_MU_wr_req,
    input  logic                                    i_MU_wr_grant,
    output logic [OFFSET_STRUCT_WIDTH-1:0]          o_MU_wr_pos,
    output logic [ELEMENT_WIDTH-1:0]                o_MU_wr_element,
    output logic [3*GLOBAL_CELL_ID_WIDTH-1:0]       o_MU_dst_gcid,
    output logic                                    o_done
);

    localparam int unsigned OW = OFFSET_WIDTH;
    localparam int unsigned CW = GLOBAL_CELL_ID_WIDTH;

    mu_state_e                    state_q, state_d;
    logic [PARTICLE_ID_WIDTH-1:0] num_q, num_d;
    logic [PARTICLE_ID_WIDTH-1:0] addr_q, addr_d;
    logic                         inflight_q, inflight_d;
    logic                         working_q, working_d;
    logic                         done_q, done_d;

    logic                         rd_en;
    logic                         fifo_empty;
    logic [MU_FIFO_CNT_W-1:0]     fifo_count;
    logic [MU_FIFO_CNT_W-1:0]     occupancy;
    logic                         can_issue;
    logic                         push;
    logic                         pop;
    mu_fifo_entry_t               push_data;
    mu_fifo_entry_t               head;

    logic [OW-1:0] new_x, new_y, new_z;
    logic [CW-1:0] cell_x, cell_y, cell_z;

    mu_cell_wrap #(.OFFSET_WIDTH(OW), .DELTA_WIDTH(DELTA_WIDTH), .CELL_WIDTH(CW),
                   .NUM_CELLS(NUM_CELLS_X)) u_wrap_x (
        .i_offset (i_pos_pkt[OW-1:0]),
        .i_delta  (i_delta[DELTA_WIDTH-1:0]),
        .i_cell   (GCELL_X),
        .o_offset (new_x),
        .o_cell   (cell_x)
    );

    mu_cell_wrap #(.OFFSET_WIDTH(OW), .DELTA_WIDTH(DELTA_WIDTH), .CELL_WIDTH(CW),
                   .NUM_CELLS(NUM_CELLS_Y)) u_wrap_y (
        .i_offset (i_pos_pkt[2*OW-1:OW]),
        .i_delta  (i_delta[2*DELTA_WIDTH-1:DELTA_WIDTH]),
        .i_cell   (GCELL_Y),
        .o_offset (new_y),
        .o_cell   (cell_y)
    );

    mu_cell_wrap #(.OFFSET_WIDTH(OW), .DELTA_WIDTH(DELTA_WIDTH), .CELL_WIDTH(CW),
                   .NUM_CELLS(NUM_CELLS_Z)) u_wrap_z (
        .i_offset (i_pos_pkt[3*OW-1:2*OW]),
        .i_delta  (i_delta[3*DELTA_WIDTH-1:2*DELTA_WIDTH]),
        .i_cell   (GCELL_Z),
        .o_offset (new_z),
        .o_cell   (cell_z)
    );

    always_comb begin
        push_data.pos     = {new_z, new_y, new_x};
        push_data.element = i_pos_pkt[OFFSET_STRUCT_WIDTH +: ELEMENT_WIDTH];
        push_data.gcid    = {cell_z, cell_y, cell_x};
        push              = i_MU_offset_valid && inflight_q;
        pop               = !fifo_empty && i_MU_wr_grant;
    end

    mu_skid_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (push),
        .i_push_data (push_data),
        .i_pop       (pop),
        .o_head      (head),
        .o_empty     (fifo_empty),
        .o_count     (fifo_count)
    );

    // Read enable is decoded from the registered state so a read can issue in
    // the same cycle a pop frees space, which sustains one particle per cycle.
    always_comb begin
        occupancy = fifo_count - MU_FIFO_CNT_W'(pop) + MU_FIFO_CNT_W'(inflight_q);
        can_issue = occupancy < MU_FIFO_CNT_W'(MU_FIFO_DEPTH);
        state_d   = state_q;
        num_d     = num_q;
        addr_d    = addr_q;
        working_d = working_q;
        done_d    = 1'b0;
        rd_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_MU_start) begin
                    state_d   = ST_RD_NUM;
                    working_d = 1'b1;
                    addr_d    = '0;
                end
            end
            ST_RD_NUM: begin
                rd_en   = 1'b1;
                state_d = ST_WAIT_NUM;
            end
            ST_WAIT_NUM: begin
                if (i_MU_offset_valid) begin
                    num_d  = i_pos_pkt[PARTICLE_ID_WIDTH-1:0];
                    addr_d = PARTICLE_ID_WIDTH'(1);
                    if (i_pos_pkt[PARTICLE_ID_WIDTH-1:0] == '0) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        working_d = 1'b0;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (can_issue) begin
                    rd_en  = 1'b1;
                    addr_d = addr_q + 1'b1;
                    if (addr_q == num_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !inflight_q) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    working_d = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        inflight_d = rd_en && (state_q == ST_STREAM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            num_q      <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            working_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            working_q  <= working_d;
            done_q     <= done_d;
            assert (!(i_MU_offset_valid && !inflight_q && state_q != ST_WAIT_NUM))
                else $error("mu_pos_updater: read data without outstanding read");
        end
    end

    assign o_MU_working    = working_q;
    assign o_done          = done_q;
    assign o_MU_rd_en      = rd_en;
    assign o_MU_rd_addr    = addr_q;
    assign o_MU_wr_req     = !fifo_empty;
    assign o_MU_wr_pos     = head.pos;
    assign o_MU_wr_element = head.element;
    assign o_MU_dst_gcid   = head.gcid;

endmodule

// File: doc/mu_pos_updater.md
Name: mu_pos_updater

Overview:
- Per-cell motion-update (MU) engine. It is the MU-side counterpart of the double-buffered position cache.
- Drives the cache's MU read port, takes back each particle's offset and element, and adds a per-particle fixed-point displacement supplied by the velocity path.
- Resolves which cell the particle belongs to after the move, including cell crossings with periodic wrap.
- Broadcasts the result on the arbitrated MU write bus toward all cells.
- Holds the cache's MU_working status high until every particle of its cell has been granted on the bus.

Parameters:
- GCELL_X, 3'h0, this cell's global X id; Y/Z identical (GCELL_Y, GCELL_Z).
- NUM_CELLS_X, 3, cells per axis for wrap; same for Y/Z (NUM_CELLS_Y, NUM_CELLS_Z).
- DELTA_WIDTH, OFFSET_WIDTH+1, signed per-axis displacement width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_MU_start  in  1  one-cycle start pulse
- o_MU_working  out  1  high from the cycle after start until done
- o_MU_rd_addr  out  PARTICLE_ID_WIDTH  cache MU read address
- o_MU_rd_en  out  1  cache MU read enable
- i_MU_offset_valid  in  1  read data valid, 1 cycle after o_MU_rd_en
- i_pos_pkt  in  OFFSET_STRUCT_WIDTH+ELEMENT_WIDTH  {element, offz, offy, offx}
- i_delta  in  3*DELTA_WIDTH  {dz, dy, dx}, aligned with i_MU_offset_valid
- o_MU_wr_req  out  1  bus request; holds until granted
- i_MU_wr_grant  in  1  bus grant
- o_MU_wr_pos  out  OFFSET_STRUCT_WIDTH  new offset
- o_MU_wr_element  out  ELEMENT_WIDTH  element, passed through
- o_MU_dst_gcid  out  3*GLOBAL_CELL_ID_WIDTH  destination {z,y,x}
- o_done  out  1  one-cycle pulse when the cell is finished

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, FIFO empty. Reset mid-operation abandons the cell with no further bus requests.
- IDLE:
  - On i_MU_start, go to RD_NUM and set o_MU_working on the next edge.
  - i_MU_start in any other state is ignored.
- RD_NUM: o_MU_rd_en=1, o_MU_rd_addr=0, one cycle. Go to WAIT_NUM.
- WAIT_NUM:
  - On i_MU_offset_valid, latch num = offx[PARTICLE_ID_WIDTH-1:0] and set the next read address to 1.
  - If num==0, go to DONE. Otherwise go to STREAM.
- STREAM:
  - Issue a read when (fifo_count + inflight) < 2 AND addr <= num. Increment addr after each issue.
  - inflight is 1 in the cycle after an issue.
  - When the read for addr==num has been issued, go to DRAIN.
- DRAIN: wait until FIFO is empty and inflight==0, then go to DONE.
- DONE:
  - o_done=1 for one cycle, o_MU_working drops to 0, return to IDLE.
  - Earliest o_done for num==0 is 3 cycles after start.
- Update arithmetic, per axis, combinational and pushed into the FIFO on i_MU_offset_valid (data reads only, never the addr-0 read):
  - s = zero-extended offset (OFFSET_WIDTH+1 bits) + sign-extended delta.
  - If s >= 2^OFFSET_WIDTH: new offset = s - 2^OFFSET_WIDTH, cell = cell+1; cell wraps from NUM_CELLS-1 to 0.
  - If s < 0: new offset = s + 2^OFFSET_WIDTH, cell = cell-1; cell wraps from 0 to NUM_CELLS-1.
  - Otherwise new offset = s, cell unchanged.
  - |delta| < 2^OFFSET_WIDTH is guaranteed upstream, so at most one crossing per axis.
- Output FIFO: 2 entries, each {pos, element, gcid}.
  - o_MU_wr_req = !empty. Outputs come from the head and stay stable while req=1 and grant=0.
  - Pop when req&grant. Push and pop in the same cycle are allowed.
  - FIFO can never overflow because of the issue throttle. Overflow is an assertion failure.
- Throughput: 1 particle/cycle when grant is held high. Latency from read issue to first possible req is 2 cycles.
- i_MU_offset_valid without an outstanding read is ignored (assertion).

Decomposition:
- MD_pkg gets: MU_FIFO_DEPTH=2, DELTA_WIDTH, NUM_CELLS_X/Y/Z defaults, and a typedef for the FIFO entry struct.
- Sub-module mu_cell_wrap: pure combinational per-axis {offset, delta, cell} -> {new offset, new cell}, instantiated 3×.
- Sub-module mu_skid_fifo: the 2-entry FIFO.

Test Plan:
- num=0: addr0 returns 0 → no o_MU_wr_req; o_done 3 cycles after start; working low after.
- num=4, grant tied 1, zero deltas → 4 requests on consecutive cycles, positions unchanged, dst gcid = own cell, addresses 1..4 read exactly once.
- Crossing on X with GCELL_X=0, NUM_CELLS_X=3, OFFSET_WIDTH=8, offx=250, dx=+10 → new offx=4, dst x=1. Same setup with offx=5, dx=-10 → new offx=251, dst x=2 (wrap).
- Backpressure: num=5, grant toggles 1 cycle on / 3 off → outputs stable while ungranted, never more than 2 entries, all 5 delivered in order, o_done after the last grant.
- Reset asserted mid-STREAM → next cycle all outputs 0; a new start redoes the cell from addr 0.
- i_MU_start asserted while working → ignored; particle count and order unchanged.
